// File: rtl/rv_axi_host_regs.sv
// rtl/rv_axi_host_regs.sv - AXI4 burst-capable register slave: control, status and mailbox words
module rv_axi_host_regs #(
    parameter int          C_S_AXI_ID_WIDTH   = 12,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_NUM_REGS         = 16,
    parameter int unsigned C_CTRL_RESET       = 1
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_areset,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                        s_axi_awlen,
    input  logic [2:0]                        s_axi_awsize,
    input  logic [1:0]                        s_axi_awburst,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wlast,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                        s_axi_arlen,
    input  logic [2:0]                        s_axi_arsize,
    input  logic [1:0]                        s_axi_arburst,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_out,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in
);
    localparam int IW  = C_S_AXI_ID_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int LSB = $clog2(SW);
    localparam int XW  = $clog2(C_NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic out_of_range(input logic [AW-1:0] a);
        return (a >> LSB) >= AW'(C_NUM_REGS);
    endfunction

    // WRAP bursts deliberately advance like INCR
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                                input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (AW'(1) << size);
    endfunction

    logic [DW-1:0] regs_q [C_NUM_REGS];

    w_state_t      w_state_q, w_state_d;
    logic [IW-1:0] awid_q;
    logic [AW-1:0] waddr_q;
    logic [7:0]    wlen_q, wbeat_q;
    logic [2:0]    wsize_q;
    logic [1:0]    wburst_q;
    logic          werr_q;
    logic          aw_hs, w_hs, w_last_beat;
    logic [XW-1:0] widx;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign widx        = waddr_q[LSB +: XW];
    assign s_axi_bid   = awid_q;
    assign s_axi_bresp = werr_q ? 2'b10 : 2'b00;
    assign ctrl_out    = regs_q[0];

    always_comb begin
        w_state_d     = w_state_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_axi_awready = !s_axi_areset;
                if (s_axi_awvalid) w_state_d = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                awid_q   <= s_axi_awid;
                waddr_q  <= s_axi_awaddr;
                wlen_q   <= s_axi_awlen;
                wsize_q  <= s_axi_awsize;
                wburst_q <= s_axi_awburst;
                wbeat_q  <= '0;
                werr_q   <= 1'b0;
            end else if (w_hs) begin
                waddr_q <= next_addr(waddr_q, wsize_q, wburst_q);
                wbeat_q <= wbeat_q + 8'd1;
                // wlast must coincide exactly with the final beat counted from awlen
                werr_q  <= werr_q | out_of_range(waddr_q) | (s_axi_wlast != w_last_beat);
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int i = 0; i < C_NUM_REGS; i++)
                regs_q[i] <= (i == 0) ? DW'(C_CTRL_RESET) : '0;
        end else if (w_hs && !out_of_range(waddr_q) && widx != XW'(1)) begin
            for (int b = 0; b < SW; b++)
                if (s_axi_wstrb[b]) regs_q[widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    r_state_t      r_state_q, r_state_d;
    logic [IW-1:0] arid_q;
    logic [AW-1:0] raddr_q, rd_addr;
    logic [7:0]    rlen_q, rbeat_q;
    logic [2:0]    rsize_q;
    logic [1:0]    rburst_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;
    logic          rlast_q;
    logic          ar_hs, r_hs, rd_load, rd_oor;
    logic [XW-1:0] rd_idx;

    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign r_hs        = s_axi_rvalid && s_axi_rready;
    // Each beat's data is fetched on the edge that accepts AR or the previous beat
    assign rd_load     = ar_hs || (r_hs && !rlast_q);
    assign rd_addr     = (r_state_q == R_IDLE) ? s_axi_araddr : next_addr(raddr_q, rsize_q, rburst_q);
    assign rd_idx      = rd_addr[LSB +: XW];
    assign rd_oor      = out_of_range(rd_addr);
    assign s_axi_rid   = arid_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;
    assign s_axi_rlast = rlast_q;

    always_comb begin
        r_state_d     = r_state_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_axi_arready = !s_axi_areset;
                if (s_axi_arvalid) r_state_d = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && rlast_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                arid_q   <= s_axi_arid;
                rlen_q   <= s_axi_arlen;
                rsize_q  <= s_axi_arsize;
                rburst_q <= s_axi_arburst;
                rbeat_q  <= '0;
                rlast_q  <= (s_axi_arlen == 8'd0);
            end else if (r_hs && !rlast_q) begin
                rbeat_q <= rbeat_q + 8'd1;
                rlast_q <= (8'(rbeat_q + 8'd1) == rlen_q);
            end
            if (rd_load) begin
                raddr_q <= rd_addr;
                rdata_q <= rd_oor ? '0 : ((rd_idx == XW'(1)) ? status_in : regs_q[rd_idx]);
                rresp_q <= rd_oor ? 2'b10 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_rv_axi_host_regs.sv
// tb/tb_rv_axi_host_regs.sv - scoreboard bench for rv_axi_host_regs with directed AXI bursts
module tb_rv_axi_host_regs;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, FIXED = 2'b00, INCR = 2'b01;

    logic        clk = 1'b0;
    logic        areset;
    logic [11:0] awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata, ctrl_out, status_in;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid;
    logic        rready = 1'b1;

    int          tests = 0, fails = 0, rcnt = 0;
    bit          rr_toggle = 1'b0;
    logic [13:0] exp_b [$];
    logic [46:0] exp_r [$];
    logic [13:0] be;
    logic [46:0] re;
    logic [31:0] wbuf [16];

    always #5 clk = ~clk;

    rv_axi_host_regs #(
        .C_S_AXI_ID_WIDTH(12), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32),
        .C_NUM_REGS(16), .C_CTRL_RESET(1)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(areset),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ctrl_out(ctrl_out), .status_in(status_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got no handshake expected one within budget", name);
    endtask

    always @(negedge clk) begin
        if (!areset && bvalid && bready) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected: got bid=%h bresp=%h expected no response", bid, bresp);
            end else begin
                be = exp_b.pop_front();
                if ({bid, bresp} !== be) begin
                    fails++;
                    $display("FAIL b_resp: got bid=%h bresp=%h expected bid=%h bresp=%h",
                             bid, bresp, be[13:2], be[1:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!areset && rvalid && rready) begin
            tests++;
            rcnt++;
            if (exp_r.size() == 0) begin
                fails++;
                $display("FAIL r_unexpected: got rid=%h rdata=%h expected no beat", rid, rdata);
            end else begin
                re = exp_r.pop_front();
                if ({rid, rresp, rlast, rdata} !== re) begin
                    fails++;
                    $display("FAIL r_beat: got rid=%h rresp=%h rlast=%b rdata=%h expected rid=%h rresp=%h rlast=%b rdata=%h",
                             rid, rresp, rlast, rdata, re[46:35], re[34:33], re[32], re[31:0]);
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        rready = rr_toggle ? ~rready : 1'b1;
    end

    task automatic push_r(input logic [11:0] id, input logic [31:0] d, input logic [1:0] resp,
                          input logic last);
        exp_r.push_back({id, resp, last, d});
    endtask

    task automatic axi_write(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input bit early_last,
                             input int abort_after, input logic [1:0] eresp);
        int n;
        if (abort_after > int'(len)) exp_b.push_back({id, eresp});
        @(posedge clk);
        #1;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 100);
        if (!awready) begin timeout_fail("aw_handshake"); awvalid = 1'b0; return; end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_after) begin wvalid = 1'b0; wlast = 1'b0; return; end
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb;
            wlast  = early_last ? (i == 0) : (i == int'(len));
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 100);
            if (!wready) begin timeout_fail("w_handshake"); wvalid = 1'b0; return; end
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        int n, target;
        target = rcnt + int'(len) + 1;
        @(posedge clk);
        #1;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 100);
        if (!arready) begin timeout_fail("ar_handshake"); arvalid = 1'b0; return; end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        while (rcnt < target && n < 200) begin @(posedge clk); n++; end
        if (rcnt < target) timeout_fail("r_beats");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1);
    end

    initial begin
        areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; status_in = 32'h5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("awready_in_reset", 32'(awready), 32'd0);
        check("arready_in_reset", 32'(arready), 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check("awready_after_reset", 32'(awready), 32'd1);
        check("arready_after_reset", 32'(arready), 32'd1);
        check("bvalid_after_reset", 32'(bvalid), 32'd0);
        check("rvalid_after_reset", 32'(rvalid), 32'd0);
        check("ctrl_reset", ctrl_out, 32'd1);
        check("rdata_reset", rdata, 32'd0);

        wbuf[0] = 32'hDEADBEEF;
        axi_write(12'h123, 32'h8, 8'd0, INCR, 4'hF, 1'b0, 999, OKAY);
        push_r(12'h045, 32'hDEADBEEF, OKAY, 1'b1);
        axi_read(12'h045, 32'h8, 8'd0, INCR);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        axi_write(12'h001, 32'h10, 8'd3, INCR, 4'hF, 1'b0, 999, OKAY);
        rr_toggle = 1'b1;
        for (int i = 0; i < 4; i++) push_r(12'h002, 32'(i + 1), OKAY, i == 3);
        axi_read(12'h002, 32'h10, 8'd3, INCR);
        rr_toggle = 1'b0;

        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        axi_write(12'h003, 32'h3C, 8'd1, INCR, 4'hF, 1'b0, 999, SLVERR);
        push_r(12'h004, 32'h0, SLVERR, 1'b1);
        axi_read(12'h004, 32'h40, 8'd0, INCR);
        push_r(12'h005, 32'h11, OKAY, 1'b1);
        axi_read(12'h005, 32'h3C, 8'd0, INCR);

        wbuf[0] = 32'hAABBCCDD;
        axi_write(12'h006, 32'h0, 8'd0, INCR, 4'h2, 1'b0, 999, OKAY);
        @(negedge clk);
        check("ctrl_strobe", ctrl_out, 32'h0000CC01);

        wbuf[0] = 32'hFFFFFFFF;
        axi_write(12'h007, 32'h4, 8'd0, INCR, 4'hF, 1'b0, 999, OKAY);
        push_r(12'h008, 32'h5A5A, OKAY, 1'b1);
        axi_read(12'h008, 32'h4, 8'd0, INCR);
        status_in = 32'h12340000;
        push_r(12'h018, 32'h12340000, OKAY, 1'b1);
        axi_read(12'h018, 32'h4, 8'd0, INCR);

        wbuf[0] = 32'h33; wbuf[1] = 32'h44;
        axi_write(12'h009, 32'h20, 8'd1, INCR, 4'hF, 1'b1, 999, SLVERR);
        push_r(12'h019, 32'h33, OKAY, 1'b0);
        push_r(12'h019, 32'h44, OKAY, 1'b1);
        axi_read(12'h019, 32'h20, 8'd1, INCR);

        wbuf[0] = 32'h7; wbuf[1] = 32'h8; wbuf[2] = 32'h9;
        axi_write(12'h00A, 32'h28, 8'd2, FIXED, 4'hF, 1'b0, 999, OKAY);
        push_r(12'h00B, 32'h9, OKAY, 1'b0);
        push_r(12'h00B, 32'h9, OKAY, 1'b1);
        axi_read(12'h00B, 32'h28, 8'd1, FIXED);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        for (int i = 0; i < 4; i++) push_r(12'h00C, 32'(i + 1), OKAY, i == 3);
        fork
            axi_write(12'h00D, 32'h30, 8'd3, INCR, 4'hF, 1'b0, 999, OKAY);
            axi_read(12'h00C, 32'h10, 8'd3, INCR);
        join
        for (int i = 0; i < 4; i++) push_r(12'h01C, 32'hA0 + 32'(i), OKAY, i == 3);
        axi_read(12'h01C, 32'h30, 8'd3, INCR);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'h55 + 32'(i);
        axi_write(12'h00E, 32'h8, 8'd3, INCR, 4'hF, 1'b0, 2, OKAY);
        @(posedge clk);
        #1;
        areset = 1'b1;
        @(negedge clk);
        check("awready_mid_reset", 32'(awready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check("ctrl_after_abort", ctrl_out, 32'd1);
        check("bvalid_after_abort", 32'(bvalid), 32'd0);
        check("awready_after_abort", 32'(awready), 32'd1);
        check("wready_after_abort", 32'(wready), 32'd0);
        for (int i = 0; i < 4; i++) push_r(12'h00F, 32'h0, OKAY, i == 3);
        axi_read(12'h00F, 32'h8, 8'd3, INCR);

        wbuf[0] = 32'h3;
        axi_write(12'h010, 32'h0, 8'd0, INCR, 4'hF, 1'b0, 999, OKAY);
        @(negedge clk);
        check("ctrl_after_rewrite", ctrl_out, 32'h3);

        repeat (5) @(posedge clk);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
